mutex_arbiter: RTL and testbench

MUTEX_ARBITER -- requirements
Module: mutex_arbiter

---
 rtl/mutex_pkg.sv | 13 +
 rtl/mutex_pick.sv | 36 +++
 rtl/mutex_arbiter.sv | 130 +++++++++++++
 tb/tb_mutex_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mutex_pkg.sv
// Shared types and constants for the mutex arbiter.
// State enum and arbitration mode selectors.
package mutex_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/mutex_pick.sv
// Combinational winner search over a request vector.
// Walks from start (up or down, wrapping) skipping an optional index.
module mutex_pick #(
  parameter int N   = 8,
  parameter int W   = $clog2(N),
  parameter bit DIR = 1'b0
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  input  logic [W-1:0] excl_i,
  input  logic         excl_en_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  int         k;
  logic [W-1:0] sel;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    k       = 0;
    sel     = '0;
    for (int i = 0; i < N; i++) begin
      if (DIR) k = (int'(start_i) + i) % N;
      else     k = (int'(start_i) - i + N) % N;
      sel = W'(k);
      if (!found_o && req_i[sel]
          && !(excl_en_i && excl_i == sel)) begin
        found_o = 1'b1;
        idx_o   = sel;
      end
    end
  end

endmodule

// File: rtl/mutex_arbiter.sv
// Registered mutex arbiter: fixed-priority or round-robin,
// with optional hold limit that forces the grant to move on.
module mutex_arbiter
  import mutex_pkg::*;
#(
  parameter int N        = 8,
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 0,
  parameter int W        = $clog2(N),
  parameter int CW       = $clog2(N+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic          grantValid,
  output logic [W-1:0]  grantIndex,
  output logic [CW-1:0] count,
  output logic          preempted
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD+1) : 1;
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  localparam bit PRE_EN = (MAX_HOLD > 0);

  state_e        state_q, state_d;
  logic [W-1:0]  idx_q, idx_d;
  logic [W-1:0]  last_q, last_d;
  logic          valid_q, valid_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pre_q, pre_d;

  logic          found, take;
  logic [W-1:0]  win, start;

  if (MODE == MODE_RR) begin : g_rr
    assign start = (last_q == W'(N-1)) ? '0 : last_q + W'(1);
  end else begin : g_fixed
    assign start = W'(N-1);
  end

  mutex_pick #(
    .N   (N),
    .W   (W),
    .DIR (MODE == MODE_RR)
  ) u_pick (
    .req_i     (req),
    .start_i   (start),
    .excl_i    (idx_q),
    .excl_en_i (state_q == GRANTED),
    .found_o   (found),
    .idx_o     (win)
  );

  assign hold_inc = (hold_q == HMAX) ? hold_q : hold_q + HW'(1);

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N; i++) cnt_d = cnt_d + CW'(req[i]);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;
    take    = 1'b0;
    unique case (state_q)
      IDLE: take = found;
      GRANTED: begin
        if (!req[idx_q]) begin
          take = found;
          if (!found) begin
            state_d = IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
          end
        end else if (PRE_EN && hold_inc == HMAX && found) begin
          // Hold limit reached with a waiter: hand over now.
          take  = 1'b1;
          pre_d = 1'b1;
        end else begin
          hold_d = hold_inc;
        end
      end
      default: ;
    endcase
    if (take) begin
      state_d = GRANTED;
      valid_d = 1'b1;
      idx_d   = win;
      last_d  = win;
      hold_d  = '0;
    end
    grant_d = valid_d ? (N'(1) << idx_d) : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= W'(N-1);
      valid_q <= 1'b0;
      grant_q <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
    end
  end

  assign grant      = grant_q;
  assign grantValid = valid_q;
  assign grantIndex = idx_q;
  assign count      = cnt_q;
  assign preempted  = pre_q;

endmodule

// File: tb/tb_mutex_arbiter.sv
// Directed bench for mutex_arbiter: fixed priority, round-robin,
// hold-limit preemption and asynchronous reset.
module tb_mutex_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req0, req1, req2;
  logic [7:0] g0, g1, g2;
  logic       v0, v1, v2;
  logic [2:0] i0, i1, i2;
  logic [3:0] c0, c1, c2;
  logic       p0, p1, p2;

  int n_cmp = 0;
  int n_err = 0;

  mutex_arbiter #(.N(8), .MODE(0), .MAX_HOLD(0)) dut0 (
    .clock(clk), .reset(rst), .req(req0), .grant(g0),
    .grantValid(v0), .grantIndex(i0), .count(c0), .preempted(p0)
  );

  mutex_arbiter #(.N(8), .MODE(1), .MAX_HOLD(0)) dut1 (
    .clock(clk), .reset(rst), .req(req1), .grant(g1),
    .grantValid(v1), .grantIndex(i1), .count(c1), .preempted(p1)
  );

  mutex_arbiter #(.N(8), .MODE(0), .MAX_HOLD(4)) dut2 (
    .clock(clk), .reset(rst), .req(req2), .grant(g2),
    .grantValid(v2), .grantIndex(i2), .count(c2), .preempted(p2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] one;
  int         prev;

  initial begin
    one  = 8'h01;
    rst  = 1'b1;
    req0 = '0;
    req1 = '0;
    req2 = '0;
    #2;
    chk("rst_grant", g0, 8'h00);
    chk("rst_valid", v0, 1'b0);
    chk("rst_index", i0, 3'd0);
    chk("rst_count", c0, 4'd0);
    chk("rst_pre", p0, 1'b0);
    #10;
    rst = 1'b0;

    // fixed priority, first grant
    req0 = 8'b0010_0101;
    tick();
    chk("fp_idx5", i0, 3'd5);
    chk("fp_grant5", g0, 8'h20);
    chk("fp_valid", v0, 1'b1);
    chk("fp_count3", c0, 4'd3);

    // higher request arrives, holder keeps grant
    req0 = 8'hA5;
    tick();
    chk("fp_hold1", i0, 3'd5);
    tick();
    chk("fp_hold2", i0, 3'd5);
    chk("fp_count4", c0, 4'd4);
    req0 = 8'h85;
    tick();
    chk("fp_b2b_idx7", i0, 3'd7);
    chk("fp_b2b_grant", g0, 8'h80);
    chk("fp_b2b_valid", v0, 1'b1);
    req0 = 8'h00;
    tick();
    chk("fp_rel_valid", v0, 1'b0);
    chk("fp_rel_grant", g0, 8'h00);
    chk("fp_rel_idx", i0, 3'd0);

    // idle stretch
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_valid", v0, 1'b0);
      chk("idle_count", c0, 4'd0);
      chk("idle_pre", p0, 1'b0);
    end
    req0 = 8'hFF;
    tick();
    chk("ones_count", c0, 4'd8);
    chk("ones_idx7", i0, 3'd7);
    req0 = 8'h00;
    tick();
    chk("ones_rel", v0, 1'b0);

    // round-robin walk with wrap
    req1 = 8'hFF;
    tick();
    chk("rr_first0", i1, 3'd0);
    chk("rr_valid", v1, 1'b1);
    prev = 0;
    for (int k = 1; k <= 8; k++) begin
      req1 = ~(one << prev);
      tick();
      chk($sformatf("rr_step%0d", k), i1, 64'(k % 8));
      prev = k % 8;
    end
    req1 = 8'h00;
    tick();
    chk("rr_rel", v1, 1'b0);

    // hold limit preemption
    req2 = 8'h44;
    tick();
    chk("mh_first6", i2, 3'd6);
    chk("mh_first_pre", p2, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("mh_hold6", i2, 3'd6);
      chk("mh_nopre", p2, 1'b0);
    end
    tick();
    chk("mh_pre_idx2", i2, 3'd2);
    chk("mh_pre_pulse", p2, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("mh_hold2", i2, 3'd2);
      chk("mh_pulse_end", p2, 1'b0);
    end
    tick();
    chk("mh_back6", i2, 3'd6);
    chk("mh_back_pulse", p2, 1'b1);

    // sole requester keeps grant past the limit
    req2 = 8'h40;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("mh_solo_idx", i2, 3'd6);
      chk("mh_solo_pre", p2, 1'b0);
    end
    req2 = 8'h44;
    tick();
    chk("mh_late_idx2", i2, 3'd2);
    chk("mh_late_pre", p2, 1'b1);
    req2 = 8'h00;
    tick();
    chk("mh_rel", v2, 1'b0);

    // asynchronous reset mid-grant
    req0 = 8'h08;
    tick();
    chk("ar_grant", g0, 8'h08);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_grant0", g0, 8'h00);
    chk("ar_valid0", v0, 1'b0);
    chk("ar_count0", c0, 4'd0);
    req0 = 8'h00;
    #2;
    rst = 1'b0;
    tick();
    chk("ar_post1", v0, 1'b0);
    tick();
    chk("ar_post2", v0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
